// File: rtl/a2d_arb_pkg.sv
// Shared types and constants for the A2D arbiter slice.
package a2d_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CHNNL_W         = 3;
    localparam int RES_W           = 12;
    localparam int DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/a2d_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx
);

    int  j;
    logic found;

    // Scan from the pointer upward modulo NUM_REQ; the first hit wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + int'(i)) % NUM_REQ;
            if (!found && req[IDX_W'(j)]) begin
                found               = 1'b1;
                winner[IDX_W'(j)]   = 1'b1;
                idx                 = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter between NUM_REQ clients,
// one conversion at a time, with a watchdog on a stuck converter.
module a2d_arbiter
    import a2d_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [CHNNL_W*NUM_REQ-1:0]   req_chnnl,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [RES_W-1:0]             res,
    output logic                         err,
    output logic                         strt_cnv,
    output logic [CHNNL_W-1:0]           chnnl,
    input  logic                         cnv_cmplt,
    input  logic [RES_W-1:0]             A2D_res
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [CHNNL_W-1:0] pick_chnnl;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               cmplt_q;
    logic               cmplt_rise;
    logic               tmo_hit;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    // Winner's channel slice and the pointer value just past the winner.
    always_comb begin
        pick_chnnl = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_chnnl = req_chnnl[i*CHNNL_W +: CHNNL_W];
            end
        end
        ptr_next   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        // Only a fresh rising edge completes; a level left high from before is ignored.
        cmplt_rise = cnv_cmplt & ~cmplt_q;
        tmo_hit    = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    end

    // Conversion sequencer: grant, start pulse, wait for completion or timeout, report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            done     <= '0;
            strt_cnv <= 1'b0;
            chnnl    <= '0;
            res      <= '0;
            err      <= 1'b0;
            cmplt_q  <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            cmplt_q <= cnv_cmplt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= pick_onehot;
                        chnnl    <= pick_chnnl;
                        ptr      <= ptr_next;
                        strt_cnv <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    strt_cnv <= 1'b0;
                    tmo_cnt  <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (cmplt_rise) begin
                        res   <= A2D_res;
                        err   <= 1'b0;
                        done  <= gnt;
                        state <= DONE;
                    end else if (tmo_hit) begin
                        res   <= '0;
                        err   <= 1'b1;
                        done  <= gnt;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/a2d_arbiter.md
# a2d_arbiter

Shares the single A2D interface (strt_cnv / chnnl / cnv_cmplt / A2D_res) between several requesters: the motion controller's IR sensor loop, the battery monitor and spare clients. Round-robin grant, one conversion at a time, watchdog timeout on a stuck converter. Sits between the client blocks and the SPI A2D interface in digicore.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- TIMEOUT, 1023: max cycles to wait for cnv_cmplt after a start
- clk  in  1  system clock; one clock domain, all logic on posedge clk
- rst  in  1  reset, asynchronous and active-high
- req  in  NUM_REQ  per-requester conversion request, level, held until done
- req_chnnl  in  3*NUM_REQ  channel per requester, slice [3i+2:3i]
- gnt  out  NUM_REQ  one-hot current owner, 0 when idle
- done  out  NUM_REQ  one-cycle pulse to owner: res/err valid
- res  out  12  conversion result, held until next capture
- err  out  1  timeout flag, valid with done
- strt_cnv  out  1  one-cycle start pulse to A2D
- chnnl  out  3  channel to A2D, stable from grant until done
- cnv_cmplt  in  1  A2D complete, level; drops after start, rises when result is ready
- A2D_res  in  12  A2D result, valid while cnv_cmplt high

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE: if any req bit is set, the round-robin picker selects the winner from the rotating pointer upward. Register gnt, latch chnnl from the winner's slice, pointer ← winner+1 mod NUM_REQ. Go to START. With no req, stay.
- START: strt_cnv=1 for exactly this cycle. Clear the timeout counter and go to WAIT.
- WAIT: registered cmplt_q tracks cnv_cmplt.
  - Rising edge (cnv_cmplt & ~cmplt_q): capture res ← A2D_res, err ← 0, go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT: res ← 12'h000, err ← 1, go to DONE.
  - A level-high cnv_cmplt left over from the previous conversion is ignored; only a rising edge completes.
- DONE: done = gnt for one cycle. Go to IDLE and clear gnt on exit.
- Requester rules:
  - Hold req and chnnl stable until done.
  - Deassert req by the edge after done, or another conversion is granted.
  - Dropping req mid-conversion does not abort it; done still pulses.
- Changing req_chnnl after grant has no effect.
- Reset: state IDLE, pointer 0, gnt 0, done 0, strt_cnv 0, chnnl 0, res 0, err 0, cmplt_q 0, counter 0. Reset mid-conversion abandons it; a later cnv_cmplt edge in IDLE is ignored.

## Timing
- Grant latency: req sampled in IDLE at edge k → gnt/chnnl valid after edge k, strt_cnv high between edges k and k+1, WAIT from edge k+1.
- Completion: rising cnv_cmplt detected at edge m → done/res/err visible after m. IDLE after m+1; earliest next grant at edge m+2.
- Overhead: 3 cycles plus converter time.
- Timeout: err at WAIT entry + TIMEOUT cycles.
- Outputs are all registered or decoded from state only; no combinational path from inputs to outputs.

## Structure
- Package a2d_arb_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, START, WAIT, DONE}
  - localparams CHNNL_W=3 and RES_W=12
  - default TIMEOUT
- Sub-module rr_picker: combinational round-robin select. Inputs req and pointer; outputs one-hot winner and index. The pointer register lives in a2d_arbiter.

## Test plan
- Single requester: req[0]=1, chnnl 3'd2, converter model returns 12'hA5C after 256 cycles → one strt_cnv, chnnl=2, done[0] pulses once, res=A5C, err=0.
- All four requesting continuously, channels 0..3 → grant order 0,1,2,3,0. chnnl matches each owner. No double grant. gnt is never multi-hot.
- Fairness after a skip: pointer at 2, only req[0] and req[3] high → 3 is granted first, then 0.
- Stuck converter: cnv_cmplt held low → done after TIMEOUT=1023 cycles in WAIT, err=1, res=000. The next request is then served normally.
- Stale cmplt: cnv_cmplt left high at the next start, then low for 10 cycles, then high → completion only on the new rising edge.
- Reset asserted during WAIT, cnv_cmplt rises afterwards → all outputs 0, no done. The next req is granted from pointer 0.
